// File: rtl/div3_pkg.sv
// Shared types and constants for the divide-by-3 scheduler: FSM states and nibble LUT widths.
package div3_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int LUT_IN_W    = 6;
   localparam int LUT_Q_W     = 4;
   localparam int LUT_R_W     = 2;
   localparam int DIV3_NIBBLE = 4;

endpackage

// File: rtl/div3_nibble_lut.sv
// Combinational divide-by-3 step: {partial remainder, nibble} -> nibble quotient and new remainder.
module div3_nibble_lut
   import div3_pkg::*;
(
   input  logic [LUT_IN_W-1:0] lut_in,
   output logic [LUT_Q_W-1:0]  quotient,
   output logic [LUT_R_W-1:0]  remainder
);

   // With a remainder of at most 2 the input never exceeds 47, so the quotient fits in 4 bits.
   assign quotient  = LUT_Q_W'(lut_in / LUT_IN_W'(3));
   assign remainder = LUT_R_W'(lut_in % LUT_IN_W'(3));

endmodule

// File: rtl/div3_sched.sv
// Round-robin shared divide-by-3 unit, one nibble per cycle.
// Optional performance counters op_count/busy_cycles when DIV3_SCHED_PERF_EN is defined.
module div3_sched
   import div3_pkg::*;
#(
   parameter int SIZE    = 20,
   parameter int NUM_REQ = 4
) (
   input  logic                       sys_clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*SIZE-1:0]    req_dividend,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [SIZE-1:0]            rsp_quotient,
   output logic [1:0]                 rsp_remainder,
   output logic                       busy
`ifdef DIV3_SCHED_PERF_EN
   ,output logic [15:0]               op_count,
   output logic [15:0]                busy_cycles
`endif
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int NNIB = SIZE / DIV3_NIBBLE;
   localparam int NW   = (NNIB > 1) ? $clog2(NNIB) : 1;

   state_t               state, state_next;
   logic [IDW-1:0]       rr_ptr, cur_id, grant_id, ptr_next;
   logic [NUM_REQ-1:0]   grant;
   logic                 grant_any;
   int                   arb_sum;
   logic [SIZE-1:0]      sel_dividend, dividend, quot;
   logic [LUT_R_W-1:0]   prem;
   logic [NW-1:0]        nib_idx;
   logic                 last_nib, handshake;
   logic [LUT_IN_W-1:0]  lut_in;
   logic [LUT_Q_W-1:0]   lut_q;
   logic [LUT_R_W-1:0]   lut_r;
   logic [SIZE+3:0]      quot_ext;

   // Round-robin arbiter: first valid requester at or after rr_ptr.
   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      arb_sum   = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         arb_sum = int'(rr_ptr) + off;
         if (arb_sum >= NUM_REQ) arb_sum = arb_sum - NUM_REQ;
         if (!grant_any && req_valid[IDW'(arb_sum)]) begin
            grant[IDW'(arb_sum)] = 1'b1;
            grant_id             = IDW'(arb_sum);
            grant_any            = 1'b1;
         end
      end
   end

   always_comb begin
      sel_dividend = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) sel_dividend = req_dividend[i*SIZE +: SIZE];
      end
   end

   assign ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign last_nib = (nib_idx == NW'(NNIB - 1));
   assign lut_in   = {prem, dividend[SIZE-1 -: DIV3_NIBBLE]};
   assign quot_ext = {quot, lut_q};

   div3_nibble_lut u_lut (
      .lut_in    (lut_in),
      .quotient  (lut_q),
      .remainder (lut_r)
   );

   always_ff @(posedge sys_clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_any) state_next = DIVIDE;
         DIVIDE:  if (last_nib)  state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is asserted, whatever the registered state.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && !reset) req_ready = grant;
      busy      = (state != IDLE) && !reset;
      rsp_valid = (state == RESP) && !reset;
      handshake = (state == RESP) && rsp_ready;
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         rr_ptr        <= '0;
         cur_id        <= '0;
         dividend      <= '0;
         quot          <= '0;
         prem          <= '0;
         nib_idx       <= '0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
      end else if (state == IDLE && grant_any) begin
         dividend <= sel_dividend;
         cur_id   <= grant_id;
         rr_ptr   <= ptr_next;
         quot     <= '0;
         prem     <= '0;
         nib_idx  <= '0;
      end else if (state == DIVIDE) begin
         dividend <= dividend << DIV3_NIBBLE;
         quot     <= quot_ext[SIZE-1:0];
         prem     <= lut_r;
         nib_idx  <= nib_idx + 1'b1;
         if (last_nib) begin
            rsp_quotient  <= quot_ext[SIZE-1:0];
            rsp_remainder <= lut_r;
            rsp_id        <= cur_id;
         end
      end
   end

`ifdef DIV3_SCHED_PERF_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         op_count    <= '0;
         busy_cycles <= '0;
      end else begin
         if (handshake) op_count    <= sat_inc(op_count);
         if (busy)      busy_cycles <= sat_inc(busy_cycles);
      end
   end
`endif

endmodule

// File: doc/div3_sched.md
DIV3_SCHED -- requirements
Module: div3_sched

Interface
REQ-001 Parameter SIZE, default 20, dividend/quotient width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter NUM_REQ, default 4, number of requesters sharing the divider; SHALL be at least 2.
REQ-003 Port sys_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NUM_REQ  per-requester request-valid.
REQ-006 Port req_dividend  input  NUM_REQ x SIZE  per-requester dividend.
REQ-007 Port req_ready  output  NUM_REQ  one-hot grant/accept strobe.
REQ-008 Port rsp_valid  output  1  result valid.
REQ-009 Port rsp_ready  input  1  result accepted by the consumer.
REQ-010 Port rsp_id  output  clog2(NUM_REQ)  index of the requester owning the result.
REQ-011 Port rsp_quotient  output  SIZE  dividend / 3.
REQ-012 Port rsp_remainder  output  2  dividend % 3, range 0..2.
REQ-013 Port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, DIVIDE and RESP.
REQ-015 In IDLE, a round-robin arbiter SHALL pick the first asserted req_valid starting at pointer rr_ptr and drive that bit of req_ready high, with all other bits low, in the same cycle (combinational).
- Outside IDLE, req_ready SHALL be all-zero.
REQ-016 Acceptance (req_valid[i] & req_ready[i]) SHALL:
- capture req_dividend[i] and i;
- clear the partial remainder and nibble index;
- set rr_ptr to (i+1) mod NUM_REQ;
- enter DIVIDE.
REQ-017 DIVIDE SHALL last exactly SIZE/4 cycles and process one nibble per cycle, MSB nibble first.
- LUT input: {partial_remainder, nibble[k]}.
- Quotient nibble k <= LUT quotient; partial_remainder <= LUT remainder.
REQ-018 After the last nibble, the FSM SHALL enter RESP. rsp_valid SHALL rise SIZE/4+1 cycles after the acceptance edge (6 cycles for the defaults).
REQ-019 In RESP, rsp_valid, rsp_id, rsp_quotient and rsp_remainder SHALL be held stable until rsp_ready is high; the FSM SHALL then return to IDLE on that edge.
- The next grant can occur in the cycle after the handshake.
REQ-020 Changes on req_valid or req_dividend after acceptance SHALL have no effect on the operation in flight.
REQ-021 Outside RESP, rsp_valid SHALL be 0. rsp_quotient, rsp_remainder and rsp_id SHALL hold the last result (0 after reset).
REQ-022 An idle cycle with no req_valid bit set SHALL leave all state unchanged.

Reset
REQ-023 When reset is high on a clock edge, the following SHALL occur regardless of state, including mid-DIVIDE or RESP:
- FSM <= IDLE; rr_ptr <= 0;
- captured dividend, quotient, partial remainder, rsp_id and nibble index <= 0;
- any operation in flight is abandoned with no response.
REQ-024 While reset is high, outputs SHALL be: req_ready = 0, rsp_valid = 0, busy = 0.

Configuration
REQ-025 With macro DIV3_SCHED_PERF_EN defined, the block SHALL add two 16-bit output ports, op_count and busy_cycles.
- op_count: increments on each RESP handshake.
- busy_cycles: increments on each cycle busy is high.
- Both saturate at 16'hFFFF and are cleared by reset.
REQ-026 Without DIV3_SCHED_PERF_EN, neither port nor its counters SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package div3_pkg SHALL hold:
- the FSM state enum (IDLE, DIVIDE, RESP);
- the nibble LUT input/output widths (6/4/2);
- constant DIV3_NIBBLE = 4.
REQ-028 The nibble LUT SHALL be the combinational sub-module div3_nibble_lut: 6-bit input {rem, nibble}, outputs quotient = input/3 (4 bits) and remainder = input%3 (2 bits). It SHALL be instantiated once, shared by all requesters.

Verification
REQ-029 Requester 0 sends 20'hFFFFF, rsp_ready=1 -> rsp_valid 6 cycles after acceptance: rsp_quotient = 20'h55555, rsp_remainder = 0, rsp_id = 0.
REQ-030 Requester 2 sends 20'd100 -> rsp_quotient = 20'd33, rsp_remainder = 1, rsp_id = 2. Requester 1 sends 20'd5 -> quotient 1, remainder 2.
REQ-031 All four req_valid high from reset with distinct dividends and rsp_ready=1 -> grants in order 0,1,2,3, each returning its own correct result. Repeated contention SHALL rotate fairly from rr_ptr.
REQ-032 rsp_ready held low 3 cycles in RESP -> rsp_valid and all rsp fields stable for 3 cycles, req_ready = 0 throughout, then IDLE the cycle after rsp_ready rises.
REQ-033 reset asserted in the 3rd DIVIDE cycle -> next cycle: busy = 0, rsp_valid = 0, outputs zero, no response for the aborted request. The next request (dividend 20'd9) is then granted from rr_ptr = 0 and returns quotient 3, remainder 0.
REQ-034 With DIV3_SCHED_PERF_EN defined, after REQ-029 completes -> op_count = 1, busy_cycles = 6 (5 DIVIDE + 1 RESP).
